// File: rtl/video_ts_pkg.sv
// Shared widths, FSM encoding and pixel helpers for the double-buffered TS-line.
package video_ts_pkg;

    localparam int TSL_AW    = 9;
    localparam int TSL_DW    = 8;
    localparam int TSL_DEPTH = 512;

    localparam logic [3:0] TSL_TRANSPARENT = 4'h0;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } tsl_state_e;

    // A TS pixel is opaque when its palette index is not the transparent one.
    function automatic logic tsl_opaque(input logic [TSL_DW-1:0] pix);
        return pix[3:0] != TSL_TRANSPARENT;
    endfunction

endpackage

// File: rtl/video_ts_line_bank.sv
// One 512x8 TS-line bank: a synchronous write port and a synchronous read port.
module video_ts_line_bank
    import video_ts_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [TSL_AW-1:0] waddr,
    input  logic [TSL_DW-1:0] wdata,
    input  logic              re,
    input  logic [TSL_AW-1:0] raddr,
    output logic [TSL_DW-1:0] rdata
);

    logic [TSL_DW-1:0] mem [TSL_DEPTH];
    logic [TSL_DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/video_ts_line_out.sv
// Front-bank scan-out of the double-buffered TS-line with clear-on-read and a
// post-reset sweep that zeroes both banks.
module video_ts_line_out
    import video_ts_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [TSL_AW-1:0] ts_waddr,
    input  logic [TSL_DW-1:0] ts_wdata,
    input  logic              ts_we,
    input  logic [TSL_AW-1:0] rd_x,
    input  logic              pix_stb,
    input  logic              rd_en,
    output logic [TSL_DW-1:0] ts_pix,
    output logic              ts_vld,
    output logic              busy,
    output logic              rbank
);

    tsl_state_e        state_q, state_d;
    logic              rbank_q, rbank_d;
    logic [TSL_AW-1:0] rptr_q, rptr_d;
    logic [TSL_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic              pend_q, pend_d;
    logic [TSL_AW-1:0] pend_addr_q, pend_addr_d;
    logic              pend_bank_q, pend_bank_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_bank_q, rd_bank_d;
    logic [TSL_DW-1:0] ts_pix_q, ts_pix_d;
    logic              ts_vld_q, ts_vld_d;

    logic              accept;
    logic [1:0]        bank_we;
    logic [1:0]        bank_re;
    logic [TSL_AW-1:0] bank_waddr [2];
    logic [TSL_DW-1:0] bank_wdata [2];
    logic [TSL_DW-1:0] bank_rdata [2];

    assign accept = (state_q == RUN) && pix_stb && rd_en && !line_start;

    always_comb begin
        state_d     = state_q;
        rbank_d     = rbank_q;
        rptr_d      = rptr_q;
        clr_cnt_d   = clr_cnt_q;
        // Bank and address are captured at issue so the clear survives a swap.
        pend_d      = accept;
        pend_addr_d = rptr_q;
        pend_bank_d = rbank_q;
        rd_vld_d    = accept;
        rd_bank_d   = rbank_q;
        ts_pix_d    = ts_pix_q;

        if (state_q == CLR) begin
            clr_cnt_d = clr_cnt_q + 9'd1;
            if (clr_cnt_q == TSL_AW'(TSL_DEPTH - 1)) begin
                state_d = RUN;
            end
        end else if (line_start) begin
            rbank_d = ~rbank_q;
            rptr_d  = rd_x;
        end else if (accept) begin
            rptr_d = rptr_q + 9'd1;
        end

        if (state_q == CLR || line_start) begin
            ts_pix_d = '0;
        end else if (rd_vld_q) begin
            ts_pix_d = bank_rdata[rd_bank_q];
        end
        ts_vld_d = tsl_opaque(ts_pix_d);
    end

    // Per-bank write mux: sweep, then delayed clear, then renderer (back bank only).
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = 1'b0;
            bank_waddr[b] = ts_waddr;
            bank_wdata[b] = ts_wdata;
            if (state_q == CLR) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = clr_cnt_q;
                bank_wdata[b] = '0;
            end else if (pend_q && pend_bank_q == 1'(b)) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = pend_addr_q;
                bank_wdata[b] = '0;
            end else if (ts_we && rbank_q != 1'(b)) begin
                bank_we[b]    = 1'b1;
            end
            bank_re[b] = accept && (rbank_q == 1'(b));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLR;
            rbank_q     <= 1'b0;
            rptr_q      <= '0;
            clr_cnt_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_bank_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_bank_q   <= 1'b0;
            ts_pix_q    <= '0;
            ts_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            rptr_q      <= rptr_d;
            clr_cnt_q   <= clr_cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_bank_q <= pend_bank_d;
            rd_vld_q    <= rd_vld_d;
            rd_bank_q   <= rd_bank_d;
            ts_pix_q    <= ts_pix_d;
            ts_vld_q    <= ts_vld_d;
        end
    end

    video_ts_line_bank u_bank0 (
        .clk   (clk),
        .we    (bank_we[0]),
        .waddr (bank_waddr[0]),
        .wdata (bank_wdata[0]),
        .re    (bank_re[0]),
        .raddr (rptr_q),
        .rdata (bank_rdata[0])
    );

    video_ts_line_bank u_bank1 (
        .clk   (clk),
        .we    (bank_we[1]),
        .waddr (bank_waddr[1]),
        .wdata (bank_wdata[1]),
        .re    (bank_re[1]),
        .raddr (rptr_q),
        .rdata (bank_rdata[1])
    );

    assign ts_pix = ts_pix_q;
    assign ts_vld = ts_vld_q;
    assign busy   = (state_q == CLR);
    assign rbank  = rbank_q;

endmodule

// File: tb/tb_video_ts_line_out.sv
// Directed bench for video_ts_line_out: sweep, latency, clear-on-read, wrap,
// bank isolation, line_start priority and mid-line reset.
module tb_video_ts_line_out;

    logic       clk;
    logic       reset;
    logic       line_start;
    logic [8:0] ts_waddr;
    logic [7:0] ts_wdata;
    logic       ts_we;
    logic [8:0] rd_x;
    logic       pix_stb;
    logic       rd_en;
    logic [7:0] ts_pix;
    logic       ts_vld;
    logic       busy;
    logic       rbank;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    video_ts_line_out dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .ts_waddr   (ts_waddr),
        .ts_wdata   (ts_wdata),
        .ts_we      (ts_we),
        .rd_x       (rd_x),
        .pix_stb    (pix_stb),
        .rd_en      (rd_en),
        .ts_pix     (ts_pix),
        .ts_vld     (ts_vld),
        .busy       (busy),
        .rbank      (rbank)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [8:0] addr, input logic [7:0] data);
        ts_we    = 1'b1;
        ts_waddr = addr;
        ts_wdata = data;
        tick();
        ts_we    = 1'b0;
    endtask

    task automatic new_line(input logic [8:0] x);
        line_start = 1'b1;
        rd_x       = x;
        tick();
        line_start = 1'b0;
    endtask

    task automatic read_burst(input int n);
        logic [7:0] e;
        rd_en = 1'b1;
        for (int i = 1; i <= n + 1; i++) begin
            pix_stb = (i <= n);
            tick();
            if (i >= 2) begin
                e = exp_q.pop_front();
                check_eq("burst_pix", 16'(ts_pix), 16'(e));
                check_eq("burst_vld", 16'(ts_vld), 16'(e[3:0] != 4'h0));
            end
        end
        pix_stb = 1'b0;
    endtask

    task automatic sweep_count(input string tag);
        int n;
        n = 0;
        while (busy && n < 600) begin
            n++;
            tick();
        end
        check_eq(tag, 16'(n), 16'd512);
    endtask

    task automatic scan_bank_zero(input string tag);
        logic [7:0] acc;
        logic       vacc;
        acc   = '0;
        vacc  = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 514; i++) begin
            pix_stb = (i < 512);
            tick();
            acc  = acc | ts_pix;
            vacc = vacc | ts_vld;
        end
        pix_stb = 1'b0;
        check_eq(tag, 16'(acc), 16'h0);
        check_eq({tag, "_vld"}, 16'(vacc), 16'h0);
    endtask

    initial begin
        reset      = 1'b1;
        line_start = 1'b0;
        ts_waddr   = '0;
        ts_wdata   = '0;
        ts_we      = 1'b0;
        rd_x       = '0;
        pix_stb    = 1'b0;
        rd_en      = 1'b0;
        repeat (3) tick();

        check_eq("rst_busy", 16'(busy), 16'h1);
        check_eq("rst_pix", 16'(ts_pix), 16'h0);
        check_eq("rst_vld", 16'(ts_vld), 16'h0);
        check_eq("rst_rbank", 16'(rbank), 16'h0);

        // Sweep length, then both banks read back as transparent
        reset = 1'b0;
        sweep_count("sweep_len");
        new_line(9'd0);
        check_eq("swap_rbank1", 16'(rbank), 16'h1);
        scan_bank_zero("sweep_bank1");
        new_line(9'd0);
        check_eq("swap_rbank0", 16'(rbank), 16'h0);
        scan_bank_zero("sweep_bank0");

        // Write then display, 2-clk latency and hold
        write_px(9'd100, 8'h5A);
        new_line(9'd100);
        check_eq("wd_rbank", 16'(rbank), 16'h1);
        rd_en   = 1'b1;
        pix_stb = 1'b1;
        tick();
        pix_stb = 1'b0;
        check_eq("wd_lat1", 16'(ts_pix), 16'h0);
        tick();
        check_eq("wd_pix", 16'(ts_pix), 16'h5A);
        check_eq("wd_vld", 16'(ts_vld), 16'h1);
        repeat (3) tick();
        check_eq("wd_hold", 16'(ts_pix), 16'h5A);

        // Clear-on-read, line_start forces output to zero
        new_line(9'd0);
        check_eq("ls_force_pix", 16'(ts_pix), 16'h0);
        check_eq("ls_force_vld", 16'(ts_vld), 16'h0);
        new_line(9'd100);
        exp_q.push_back(8'h00);
        read_burst(1);

        // Pointer wrap 510,511,0,1
        write_px(9'd510, 8'h01);
        write_px(9'd511, 8'h02);
        write_px(9'd0,   8'h03);
        write_px(9'd1,   8'h04);
        new_line(9'd510);
        check_eq("wrap_rbank", 16'(rbank), 16'h0);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        read_burst(4);

        // Bank isolation: back-bank writes to the addresses being scanned
        write_px(9'd20, 8'h21);
        write_px(9'd21, 8'h32);
        new_line(9'd20);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h32);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_stb  = (i < 2);
            ts_we    = (i < 2);
            ts_waddr = 9'(20 + i);
            ts_wdata = 8'hFF;
            tick();
            if (i >= 1) begin
                check_eq("iso_front", 16'(ts_pix), 16'(exp_q.pop_front()));
            end
        end
        pix_stb = 1'b0;
        ts_we   = 1'b0;
        new_line(9'd20);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        read_burst(2);

        // line_start wins over pix_stb; rd_en gates the strobe
        write_px(9'd40, 8'h17);
        write_px(9'd41, 8'h26);
        write_px(9'd42, 8'h35);
        line_start = 1'b1;
        rd_x       = 9'd40;
        pix_stb    = 1'b1;
        rd_en      = 1'b1;
        tick();
        line_start = 1'b0;
        rd_en      = 1'b0;
        check_eq("prio_rbank", 16'(rbank), 16'h1);
        repeat (2) tick();
        pix_stb = 1'b0;
        check_eq("gate_pix", 16'(ts_pix), 16'h0);
        exp_q.push_back(8'h17);
        read_burst(1);

        // Reset in the middle of a line acts immediately
        rd_en   = 1'b1;
        pix_stb = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 16'(busy), 16'h1);
        check_eq("mid_rst_pix", 16'(ts_pix), 16'h0);
        check_eq("mid_rst_vld", 16'(ts_vld), 16'h0);
        check_eq("mid_rst_rbank", 16'(rbank), 16'h0);
        pix_stb = 1'b0;
        rd_en   = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        sweep_count("sweep_len2");
        new_line(9'd42);
        check_eq("post_rst_rbank", 16'(rbank), 16'h1);
        exp_q.push_back(8'h00);
        read_burst(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
